// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Bit counter must hold 0..N+1 so the same width covers the parity build.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// Output holding register for assembled words with valid/ready handshake and overrun flag.
// Latency: word presented on word_vld appears on p_out/p_valid one cycle later.
// Backpressure: none upstream; a word arriving while a held word is stalled is dropped and flagged.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   word_vld, word_dat  completed word from the shift stage (single-cycle pulse)
//   p_ready             consumer accepts p_out this cycle
//   clr_err             synchronous clear of overrun (a same-cycle set wins)
//   p_out, p_valid      held word and its valid flag
//   overrun             sticky: a completed word was dropped
module sipo_out_buffer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         word_vld,
    input  logic [N-1:0] word_dat,
    input  logic         p_ready,
    input  logic         clr_err,
    output logic [N-1:0] p_out,
    output logic         p_valid,
    output logic         overrun
);

    logic can_load;
    logic drop;

    // The slot is free if empty or being drained this very cycle, so
    // back-to-back words never leave a bubble.
    assign can_load = !p_valid || p_ready;
    assign drop     = word_vld && !can_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (word_vld && can_load) begin
                p_out   <= word_dat;
                p_valid <= 1'b1;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial-in/parallel-out receiver, MSB- or LSB-first framing, double-buffered output.
// Latency: word visible on p_out the cycle after its last bit (or parity bit) is sampled.
// Backpressure: serial side never stalls; a word completing while p_out is stalled is dropped (overrun).
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ser_in, ser_valid            serial bit and its strobe
//   frame_start                  first bit of a frame (only meaningful with ser_valid)
//   dir                          0 = MSB-first, 1 = LSB-first, latched on the frame_start bit
//   p_ready, p_out, p_valid      parallel output handshake
//   clr_err                      clears overrun/frame_err/parity_err (a same-cycle set wins)
//   busy                         frame in progress
//   overrun, frame_err, parity_err  sticky error flags
// Build option: define SIPO_PARITY_EN to append an even-parity bit to every frame;
// otherwise parity_err is tied low.
module serial_frame_deserializer
    import serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         frame_start,
    input  logic         dir,
    input  logic         p_ready,
    input  logic         clr_err,
    output logic [N-1:0] p_out,
    output logic         p_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int CW = cnt_width(N);
`ifdef SIPO_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sh;
    logic           dir_q;

    logic [N-1:0]   sh_first;
    logic [N-1:0]   sh_shift;
    logic           frame_begin;
    logic           restart;
    logic           bit_acc;
    logic           last_bit;
    logic           word_vld;
    logic [N-1:0]   word_dat;
    logic           par_fail;

    always_comb begin
        // A new frame starts from a clean register so a restarted frame
        // carries nothing over from the abandoned one.
        sh_first    = (dir == DIR_LSB_FIRST) ? {ser_in, {(N-1){1'b0}}}
                                             : {{(N-1){1'b0}}, ser_in};
        sh_shift    = (dir_q == DIR_LSB_FIRST) ? {ser_in, sh[N-1:1]}
                                               : {sh[N-2:0], ser_in};
        frame_begin = ser_valid && frame_start;
        restart     = frame_begin && (state == S_SHIFT);
        bit_acc     = ser_valid && !frame_start && (state == S_SHIFT);
        last_bit    = bit_acc && (cnt == CW'(L - 1));
`ifdef SIPO_PARITY_EN
        // Last bit is parity: the data word is already complete in sh.
        word_dat    = sh;
        par_fail    = last_bit && ((^sh) ^ ser_in);
        word_vld    = last_bit && !par_fail;
`else
        word_dat    = sh_shift;
        par_fail    = 1'b0;
        word_vld    = last_bit;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sh    <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (frame_begin) begin
            state <= S_SHIFT;
            cnt   <= CW'(1);
            dir_q <= dir;
            sh    <= sh_first;
        end else if (bit_acc) begin
            if (last_bit) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + CW'(1);
            end
            // Only data bits enter the register; a trailing parity bit does not.
            if (cnt < CW'(N)) begin
                sh <= sh_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (restart) begin
            frame_err <= 1'b1;
        end else if (clr_err) begin
            frame_err <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (par_fail) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = par_fail;
`endif

    assign busy = (state == S_SHIFT);

    sipo_out_buffer #(
        .N (N)
    ) u_out_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .word_vld (word_vld),
        .word_dat (word_dat),
        .p_ready  (p_ready),
        .clr_err  (clr_err),
        .p_out    (p_out),
        .p_valid  (p_valid),
        .overrun  (overrun)
    );

endmodule
